// File: rtl/kyber_mem_pkg.sv
// Shared definitions for the Kyber bulk-memory port B arbiter.
package kyber_mem_pkg;

    localparam int KY_VEC_W   = 6400;
    localparam int KY_CHUNK_W = 128;

    // Value carried on web for the two transaction kinds.
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/kyber_ram_port_arbiter_if.sv
// Port B bus between the arbiter (master) and the chunked two-port RAM (slave).
interface kyber_ram_port_arbiter_if
    import kyber_mem_pkg::*;
#(
    parameter int DATA_WIDTH = KY_VEC_W
) ();

    logic                  enb;
    logic                  web;
    logic [DATA_WIDTH-1:0] dinb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  r_done;
    logic                  w_done;

    modport master (output enb, web, dinb, input doutb, r_done, w_done);
    modport slave  (input enb, web, dinb, output doutb, r_done, w_done);

endinterface

// File: rtl/kyber_ram_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational winner, registered last-owner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] win
);

    // 1 = requester 1 was granted last, so requester 0 wins the first tie.
    logic rr_last;

    // Single requester wins outright; a tie goes to whoever did not own last.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = rr_last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    // Remember the owner only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_last <= 1'b1;
        else if (take) rr_last <= win[1];
    end

endmodule

// File: rtl/kyber_ram_port_arbiter.sv
// Grants RAM port B to one of two whole-vector requesters and sequences the
// IDLE -> RUN -> FLUSH handshake, including abort and timeout recovery.
module kyber_ram_port_arbiter
    import kyber_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = KY_VEC_W,
    parameter int CHUNK_WIDTH = KY_CHUNK_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_i,
    input  logic [1:0]            wr_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]            grant_o,
    output logic [1:0]            done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    kyber_ram_port_arbiter_if.master ram
);

    localparam int TOTAL_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int TMO_W        = $clog2(TIMEOUT_CYC);

    // The timeout must leave room for a nominal transaction to finish.
    if (TIMEOUT_CYC <= TOTAL_CHUNKS + 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC too small for DATA_WIDTH/CHUNK_WIDTH");
    end

    arb_state_e       state_q, state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [1:0]       win;
    logic             take, fin_done, fin_abort, fin_tmo, fin_any;
    logic             op_done, owner_req, win_wr;

    rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_i),
        .take  (take),
        .win   (win)
    );

    assign op_done   = (ram.web == OP_WR) ? ram.w_done : ram.r_done;
    assign owner_req = |(req_i & grant_o);
    assign win_wr    = win[1] ? wr_i[1] : wr_i[0];
    assign fin_any   = fin_done | fin_abort | fin_tmo;
    // RAM counters run only while a transaction owns the port.
    assign ram.enb   = (state_q == RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and transaction-end classification; done beats abort beats timeout.
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        fin_done  = 1'b0;
        fin_abort = 1'b0;
        fin_tmo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    take    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (op_done)                              fin_done  = 1'b1;
                else if (!owner_req)                      fin_abort = 1'b1;
                else if (tmo_q == TMO_W'(TIMEOUT_CYC-1))  fin_tmo   = 1'b1;
                if (fin_done || fin_abort || fin_tmo)     state_d   = FLUSH;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant/operand capture, completion pulses, read-data latch and timeout count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_o  <= '0;
            done_o   <= '0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            ram.web  <= 1'b0;
            ram.dinb <= '0;
            tmo_q    <= '0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            if (take) begin
                grant_o  <= win;
                ram.web  <= win_wr;
                ram.dinb <= win[1] ? wdata1_i : wdata0_i;
                tmo_q    <= '0;
            end else if (state_q == RUN) begin
                if (fin_done) begin
                    done_o <= grant_o;
                    if (ram.web == OP_RD) rdata_o <= ram.doutb;
                end
                if (fin_tmo) err_o <= 1'b1;
                if (fin_any) grant_o <= '0;
                else         tmo_q   <= tmo_q + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_kyber_ram_port_arbiter.sv
// Bench for kyber_ram_port_arbiter with a behavioural chunked RAM on port B.
module tb_kyber_ram_port_arbiter;
    import kyber_mem_pkg::*;

    localparam int DW  = KY_VEC_W;
    localparam int CW  = KY_CHUNK_W;
    localparam int NCH = DW / CW;

    typedef struct {
        logic [1:0]    done;
        logic          err;
        logic          chk_rd;
        logic [DW-1:0] rd;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_i = '0;
    logic [1:0]    wr_i = '0;
    logic [DW-1:0] wdata0_i = '0;
    logic [DW-1:0] wdata1_i = '0;
    logic [1:0]    grant_o, done_o;
    logic          err_o;
    logic [DW-1:0] rdata_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];

    kyber_ram_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    kyber_ram_port_arbiter #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW), .TIMEOUT_CYC(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .wr_i     (wr_i),
        .wdata0_i (wdata0_i),
        .wdata1_i (wdata1_i),
        .grant_o  (grant_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .ram      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: one chunk per enabled cycle, done flag one cycle after the last chunk.
    logic [CW-1:0] mem [NCH];
    int  scnt = 0;
    bit  stub_kill = 1'b0;
    always @(posedge clk) begin
        if (!bus.enb) begin
            scnt <= 0;
            bus.r_done <= 1'b0;
            bus.w_done <= 1'b0;
        end else if (scnt < NCH) begin
            if (bus.web) mem[scnt] <= bus.dinb[scnt*CW +: CW];
            else         bus.doutb[scnt*CW +: CW] <= mem[scnt];
            scnt <= scnt + 1;
        end else if (!stub_kill) begin
            if (bus.web) bus.w_done <= 1'b1;
            else         bus.r_done <= 1'b1;
        end
    end

    function automatic logic [DW-1:0] gen_pat(int k);
        logic [DW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*CW +: CW] = {4{32'(k * (i + 1))}};
        return v;
    endfunction

    function automatic logic [DW-1:0] mem_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*CW +: CW] = mem[i];
        return v;
    endfunction

    function automatic exp_t mk_exp(logic [1:0] d, logic e, logic c, logic [DW-1:0] r, int l);
        exp_t x;
        x.done = d; x.err = e; x.chk_rd = c; x.rd = r; x.lat = l;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: low64 got %h expected %h (t=%0t)", name, act[63:0], exp[63:0], $time);
        end
    endtask

    // Scoreboard monitor: every done/err pulse must match the oldest expectation.
    initial begin : monitor
        logic [1:0] prev_grant = '0;
        logic       prev_enb = 1'b0;
        int         low_run = 100;
        int         grant_cyc = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (grant_o != 2'b00 && prev_grant == 2'b00) grant_cyc = cyc;
                if (bus.enb && !prev_enb) check("enb_low_gap_ge2", 32'(low_run >= 2), 32'd1);
                if (done_o != 2'b00 || err_o) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse: done=%b err=%b (t=%0t)", done_o, err_o, $time);
                    end else begin
                        e = sb.pop_front();
                        check("done_o", 32'(done_o), 32'(e.done));
                        check("err_o", 32'(err_o), 32'(e.err));
                        if (e.lat > 0) check("latency", 32'(cyc - grant_cyc), 32'(e.lat));
                        if (e.chk_rd) check_vec("rdata_o", rdata_o, e.rd);
                        check("flush_enb", 32'(bus.enb), 32'd0);
                        check("flush_grant", 32'(grant_o), 32'd0);
                    end
                end
            end
            low_run = bus.enb ? 0 : low_run + 1;
            prev_enb = bus.enb;
            prev_grant = grant_o;
        end
    end

    task automatic wait_end(input int r, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done_o[r] || err_o) && n < 300);
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done/err after %0d cycles, expected pulse", name, n);
        end
    endtask

    task automatic run_txn(input int r, input logic wr, input logic [DW-1:0] wd, input exp_t e, input string name);
        sb.push_back(e);
        if (r == 0) wdata0_i = wd; else wdata1_i = wd;
        wr_i[r]  = wr;
        req_i[r] = 1'b1;
        wait_end(r, name);
        req_i[r] = 1'b0;
    endtask

    initial begin : stim
        logic [DW-1:0] pa, pb, pc;
        int n;
        pa = gen_pat(32'h01010101);
        pb = gen_pat(32'h00370011);
        pc = gen_pat(32'h0BADC0DE);

        // Reset state.
        #12;
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_enb", 32'(bus.enb), 32'd0);
        check("rst_web", 32'(bus.web), 32'd0);
        check_vec("rst_rdata", rdata_o, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write by requester 0, then read back by requester 1.
        run_txn(0, OP_WR, pa, mk_exp(2'b01, 1'b0, 1'b0, '0, NCH + 2), "wr0");
        check_vec("mem_after_wr0", mem_vec(), pa);
        run_txn(1, OP_RD, '0, mk_exp(2'b10, 1'b0, 1'b1, pa, NCH + 2), "rd1");

        // Both requesting for four transactions: strict alternation starting at 0.
        sb.push_back(mk_exp(2'b01, 1'b0, 1'b1, pa, NCH + 2));
        sb.push_back(mk_exp(2'b10, 1'b0, 1'b1, pa, NCH + 2));
        sb.push_back(mk_exp(2'b01, 1'b0, 1'b1, pa, NCH + 2));
        sb.push_back(mk_exp(2'b10, 1'b0, 1'b1, pa, NCH + 2));
        wr_i = 2'b00;
        req_i = 2'b11;
        n = 0;
        for (int k = 0; k < 4 && n < 600; ) begin
            @(negedge clk);
            n++;
            if (done_o != 2'b00 || err_o) k++;
        end
        req_i = 2'b00;
        check("alt_finished_in_budget", 32'(n < 600), 32'd1);

        // RAM never reports done: timeout after 64 RUN cycles, rdata untouched.
        stub_kill = 1'b1;
        run_txn(0, OP_RD, '0, mk_exp(2'b00, 1'b1, 1'b0, '0, 64), "tmo");
        stub_kill = 1'b0;
        check_vec("rdata_after_tmo", rdata_o, pa);

        // New contents from requester 1.
        run_txn(1, OP_WR, pb, mk_exp(2'b10, 1'b0, 1'b0, '0, NCH + 2), "wr1");
        check_vec("mem_after_wr1", mem_vec(), pb);

        // Requester 0 abandons a read after 10 cycles.
        wr_i[0] = OP_RD;
        req_i[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (grant_o != 2'b01 && n < 20);
        check("abort_granted", 32'(grant_o), 32'h1);
        repeat (10) @(negedge clk);
        req_i[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_grant_clear", 32'(grant_o), 32'd0);
        check("abort_enb_low", 32'(bus.enb), 32'd0);
        check_vec("abort_rdata_kept", rdata_o, pa);
        run_txn(1, OP_RD, '0, mk_exp(2'b10, 1'b0, 1'b1, pb, NCH + 2), "rd1_after_abort");

        // Asynchronous reset in the middle of a write.
        wdata0_i = pc;
        wr_i[0] = OP_WR;
        req_i[0] = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_grant", 32'(grant_o), 32'd0);
        check("midrst_enb", 32'(bus.enb), 32'd0);
        check("midrst_web", 32'(bus.web), 32'd0);
        check_vec("midrst_dinb", bus.dinb, '0);
        check_vec("midrst_rdata", rdata_o, '0);
        req_i = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(0, OP_WR, pc, mk_exp(2'b01, 1'b0, 1'b0, '0, NCH + 2), "wr0_after_rst");
        check_vec("mem_after_rst_wr", mem_vec(), pc);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
